rv32i_decode_stage: RTL and testbench

//  Registered RV32I decode stage between fetch and execute. Accepts {pc, instr} on a

---
 rtl/rv32i_pkg.sv | 47 ++++
 rtl/rv32i_imm_gen.sv | 32 +++
 rtl/rv32i_decode_stage.sv | 134 +++++++++++++
 tb/tb_rv32i_decode_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Purpose: shared RV32I decode types: opcodes, immediate selector, control flags, decoded entry.
// Latency: n/a. This file holds declarations only.
// Backpressure: n/a.
package rv32i_pkg;

    // pc/imm fields are stored at the widest legal XLEN. Users slice them down to their own XLEN.
    localparam int XLEN_MAX = 64;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_sel_e;

    typedef struct packed {
        logic reg_we;
        logic mem_re;
        logic mem_we;
        logic branch;
        logic jump;
        logic alu_src_imm;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        imm_sel_e            imm_sel;
        logic [XLEN_MAX-1:0] imm;
        ctrl_t               ctrl;
        logic                illegal;
    } decoded_t;

endpackage

// File: rtl/rv32i_imm_gen.sv
// Purpose: RV32I immediate generator. It maps instr[31:7] and imm_sel to an XLEN-bit sign-extended immediate.
// Latency: combinational, no registers.
// Backpressure: none; this is pure logic.
// Ports: instr (instruction bits 31:7), imm_sel (I/S/B/J/U), imm (sign-extended result).
module rv32i_imm_gen
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  imm_sel_e        imm_sel,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (imm_sel)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            default: imm32 = '0;
        endcase
    end

    // Every format takes its sign from instr[31]. Widening as signed therefore extends correctly to XLEN=64.
    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/rv32i_decode_stage.sv
// Purpose: registered RV32I decode stage that sits between fetch and execute.
// Latency: an entry accepted at an edge is presented right after that edge when the buffer was empty.
// Backpressure: a 2-entry skid buffer (M drives the outputs, S absorbs one entry). in_ready = !S.valid is registered.
// Ports: clk/rst (asynchronous active-high reset); flush drops all entries.
//        in_* is the fetch handshake with pc and instr. out_* is the decoded entry towards execute.
module rv32i_decode_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int IMM_SEL_W = 3,
    parameter bit EN_AUIPC  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [31:0]          in_instr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [4:0]           out_rs1,
    output logic [4:0]           out_rs2,
    output logic [4:0]           out_rd,
    output logic [IMM_SEL_W-1:0] out_imm_sel,
    output logic [XLEN-1:0]      out_imm,
    output ctrl_t                out_ctrl,
    output logic                 out_illegal
);

    imm_sel_e        dec_sel;
    ctrl_t           dec_ctrl;
    logic            dec_ill;
    logic [XLEN-1:0] dec_imm;
    decoded_t        dec;

    decoded_t        m_q;
    decoded_t        s_q;
    logic            m_vld;
    logic            s_vld;
    logic            accept;

    rv32i_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr   (in_instr[31:7]),
        .imm_sel (dec_sel),
        .imm     (dec_imm)
    );

    // alu_src_imm marks an immediate that feeds ALU operand B.
    // This applies to the I/S/U formats, and jalr uses it for its rs1+imm target.
    always_comb begin
        dec_sel  = IMM_I;
        dec_ctrl = '0;
        dec_ill  = 1'b0;
        case (in_instr[6:0])
            OP_LOAD:   begin dec_ctrl.reg_we = 1'b1; dec_ctrl.mem_re = 1'b1; dec_ctrl.alu_src_imm = 1'b1; end
            OP_STORE:  begin dec_sel = IMM_S; dec_ctrl.mem_we = 1'b1; dec_ctrl.alu_src_imm = 1'b1; end
            OP_REG:    begin dec_ctrl.reg_we = 1'b1; end
            OP_BRANCH: begin dec_sel = IMM_B; dec_ctrl.branch = 1'b1; end
            OP_IMM:    begin dec_ctrl.reg_we = 1'b1; dec_ctrl.alu_src_imm = 1'b1; end
            OP_JAL:    begin dec_sel = IMM_J; dec_ctrl.jump = 1'b1; dec_ctrl.reg_we = 1'b1; end
            OP_JALR:   begin dec_ctrl.jump = 1'b1; dec_ctrl.reg_we = 1'b1; dec_ctrl.alu_src_imm = 1'b1; end
            OP_LUI:    begin dec_sel = IMM_U; dec_ctrl.reg_we = 1'b1; dec_ctrl.alu_src_imm = 1'b1; end
            OP_AUIPC: begin
                if (EN_AUIPC) begin
                    dec_sel = IMM_U; dec_ctrl.reg_we = 1'b1; dec_ctrl.alu_src_imm = 1'b1;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            default:   dec_ill = 1'b1;
        endcase
    end

    always_comb begin
        dec         = '0;
        dec.pc      = XLEN_MAX'(in_pc);
        dec.rs1     = in_instr[19:15];
        dec.rs2     = in_instr[24:20];
        dec.rd      = in_instr[11:7];
        dec.imm_sel = dec_sel;
        dec.imm     = dec_ill ? '0 : XLEN_MAX'(dec_imm);
        dec.ctrl    = dec_ctrl;
        dec.illegal = dec_ill;
    end

    assign in_ready = !s_vld;
    assign accept   = in_valid && in_ready;

    // An empty M implies an empty S. So when M frees up, S is drained first, and only then is a new entry taken in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_vld <= 1'b0;
            s_vld <= 1'b0;
            m_q   <= '0;
            s_q   <= '0;
        end else if (flush) begin
            m_vld <= 1'b0;
            s_vld <= 1'b0;
        end else if (!m_vld || out_ready) begin
            if (s_vld) begin
                m_q   <= s_q;
                m_vld <= 1'b1;
                s_vld <= 1'b0;
            end else if (accept) begin
                m_q   <= dec;
                m_vld <= 1'b1;
            end else begin
                m_vld <= 1'b0;
            end
        end else if (accept) begin
            s_q   <= dec;
            s_vld <= 1'b1;
        end
    end

    assign out_valid   = m_vld;
    assign out_pc      = m_q.pc[XLEN-1:0];
    assign out_rs1     = m_q.rs1;
    assign out_rs2     = m_q.rs2;
    assign out_rd      = m_q.rd;
    assign out_imm_sel = IMM_SEL_W'(m_q.imm_sel);
    assign out_imm     = m_q.imm[XLEN-1:0];
    assign out_ctrl    = m_q.ctrl;
    assign out_illegal = m_q.illegal;

    // When XLEN is narrower than storage, the upper bits of M are don't-care. They are collected here so that they are visibly unused.
    if (XLEN < XLEN_MAX) begin : g_narrow
        logic unused_hi;
        assign unused_hi = ^{m_q.pc[XLEN_MAX-1:XLEN], m_q.imm[XLEN_MAX-1:XLEN]};
    end

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Purpose: scoreboard bench for rv32i_decode_stage, built with XLEN=32 and EN_AUIPC=0.
// Latency: the driver pushes the expected entry when a handshake will occur. The monitor pops it on each output handshake.
// Backpressure: out_ready is driven by directed tests to stall, flush and reset the pipe.
module tb_rv32i_decode_stage;
    import rv32i_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [2:0]  out_imm_sel;
    logic [31:0] out_imm;
    ctrl_t       out_ctrl;
    logic        out_illegal;

    rv32i_decode_stage #(.XLEN(32), .IMM_SEL_W(3), .EN_AUIPC(1'b0)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_rd      (out_rd),
        .out_imm_sel (out_imm_sel),
        .out_imm     (out_imm),
        .out_ctrl    (out_ctrl),
        .out_illegal (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  sel;
        logic [31:0] imm;
        logic [5:0]  ctrl;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rst_pulses = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [2:0] sel, input logic [31:0] imm,
                                input logic [5:0] ctrl, input logic ill);
        exp_t e;
        e.pc = '0; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
        e.sel = sel; e.imm = imm; e.ctrl = ctrl; e.ill = ill;
        return e;
    endfunction

    // Called just after a posedge. It holds the offer until the DUT is ready, and returns just after the accepting edge.
    task automatic send(input logic [31:0] pc, input logic [31:0] instr, input exp_t e);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready && !flush) begin
                e.pc = pc;
                exp_q.push_back(e);
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        n_cmp++; n_bad++;
        $display("FAIL send_timeout: in_ready stayed 0 for pc %h", pc);
        in_valid = 1'b0;
    endtask

    // Monitor: it scores every output handshake and checks that the outputs stay stable while stalled.
    logic        hold_vld = 1'b0;
    logic [31:0] hold_pc, hold_imm;
    int          hold_rc;
    exp_t        m_e;

    always @(negedge clk) begin
        if (hold_vld && rst_pulses == hold_rc)
            check("hold_stable", {out_valid, out_pc, out_imm}, {1'b1, hold_pc, hold_imm});
        hold_vld = out_valid && !out_ready && !flush && !rst;
        hold_pc  = out_pc;
        hold_imm = out_imm;
        hold_rc  = rst_pulses;
        if (!rst && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_output: got pc %h, required no output", out_pc);
            end else begin
                m_e = exp_q.pop_front();
                check("entry", {out_pc, out_rs1, out_rs2, out_rd, out_imm_sel, out_imm, 6'(out_ctrl), out_illegal},
                      {m_e.pc, m_e.rs1, m_e.rs2, m_e.rd, m_e.sel, m_e.imm, m_e.ctrl, m_e.ill});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hs;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b1;
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_imm", out_imm, 32'h0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // addi, then check the one-cycle latency
        send(32'h100, 32'h00500093, mk(5'd0, 5'd5, 5'd1, 3'd0, 32'd5, 6'h21, 1'b0));
        check("lat_valid", out_valid, 1'b1);
        check("lat_pc", out_pc, 32'h100);

        // back-to-back mix of formats, auipc disabled, and illegal opcodes
        send(32'h104, 32'h0020A423, mk(5'd1, 5'd2, 5'd8, 3'd1, 32'd8, 6'h09, 1'b0));
        send(32'h108, 32'hFE000EE3, mk(5'd0, 5'd0, 5'd29, 3'd2, 32'hFFFFFFFC, 6'h04, 1'b0));
        send(32'h10C, 32'h123452B7, mk(5'd8, 5'd3, 5'd5, 3'd4, 32'h12345000, 6'h21, 1'b0));
        send(32'h110, 32'h12345297, mk(5'd8, 5'd3, 5'd5, 3'd0, 32'h0, 6'h00, 1'b1));
        send(32'h114, 32'hFFFFFFFF, mk(5'd31, 5'd31, 5'd31, 3'd0, 32'h0, 6'h00, 1'b1));
        send(32'h118, 32'h008000EF, mk(5'd0, 5'd8, 5'd1, 3'd3, 32'd8, 6'h22, 1'b0));
        send(32'h11C, 32'hFFC12183, mk(5'd2, 5'd28, 5'd3, 3'd0, 32'hFFFFFFFC, 6'h31, 1'b0));
        repeat (3) @(posedge clk); #1;

        // stream of 8 instructions with a 3-cycle stall mid-stream
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(32'h200 + 32'(4 * i), {12'(i), 5'd0, 3'b000, 5'(i), 7'b0010011},
                         mk(5'd0, 5'(i), 5'(i), 3'd0, 32'(i), 6'h21, 1'b0));
            end
            begin
                repeat (3) @(posedge clk); #1;
                out_ready = 1'b0;
                @(negedge clk); check("stall1_in_ready", in_ready, 1'b1);
                @(negedge clk); check("stall2_in_ready", in_ready, 1'b0);
                @(negedge clk); check("stall3_in_ready", in_ready, 1'b0);
                @(posedge clk); #1;
                out_ready = 1'b1;
                hs = 0;
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    if (k == 0) check("release_in_ready0", in_ready, 1'b0);
                    if (k == 1) check("release_in_ready1", in_ready, 1'b1);
                    if (out_valid && out_ready) hs++;
                end
                check("release_throughput", hs, 6);
            end
        join
        repeat (3) @(posedge clk); #1;
        check("stream_drained", exp_q.size(), 0);

        // flush with both entries full; the offered instruction is not accepted
        out_ready = 1'b0;
        send(32'h400, 32'h00100093, mk(5'd0, 5'd1, 5'd1, 3'd0, 32'd1, 6'h21, 1'b0));
        send(32'h404, 32'h00200113, mk(5'd0, 5'd2, 5'd2, 3'd0, 32'd2, 6'h21, 1'b0));
        check("full_in_ready", in_ready, 1'b0);
        in_valid = 1'b1; in_pc = 32'h408; in_instr = 32'h00300193; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_in_ready", in_ready, 1'b1);
        // flush with a live handshake in the same cycle: flush wins
        send(32'h40C, 32'h00400213, mk(5'd0, 5'd4, 5'd4, 3'd0, 32'd4, 6'h21, 1'b0));
        in_valid = 1'b1; in_pc = 32'h410; in_instr = 32'h00500293; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        check("flush2_out_valid", out_valid, 1'b0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); check("flushed_never_out", out_valid, 1'b0);
        end
        @(posedge clk); #1;

        // asynchronous reset pulse between edges while entries are buffered
        out_ready = 1'b0;
        send(32'h500, 32'h00600313, mk(5'd0, 5'd6, 5'd6, 3'd0, 32'd6, 6'h21, 1'b0));
        send(32'h504, 32'h00700393, mk(5'd0, 5'd7, 5'd7, 3'd0, 32'd7, 6'h21, 1'b0));
        #1 rst = 1'b1; rst_pulses++;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_in_ready", in_ready, 1'b1);
        check("arst_out_pc", out_pc, 32'h0);
        exp_q.delete();
        #1 rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(32'h600, 32'hFFF00413, mk(5'd0, 5'd31, 5'd8, 3'd0, 32'hFFFFFFFF, 6'h21, 1'b0));
        check("post_rst_lat_valid", out_valid, 1'b1);
        check("post_rst_lat_pc", out_pc, 32'h600);
        repeat (3) @(posedge clk); #1;
        check("final_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
